// File: rtl/uart_frame_sched.sv
// Round-robin frame scheduler for a byte-wide UART transmitter: arbitrates two
// requesters, frames each payload (header, src/len, payload, XOR checksum) and paces the bytes.
module uart_frame_sched #(
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned GAP     = 2,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [2:0]  len0,
  input  logic [31:0] pay0,
  output logic        ack0,
  input  logic        req1,
  input  logic [2:0]  len1,
  input  logic [31:0] pay1,
  output logic        ack1,
  output logic        send_en,
  output logic [7:0]  data,
  input  logic        tx_done,
  output logic        busy,
  output logic        grant_id,
  output logic        frame_done,
  output logic        err_timeout,
  output logic        err_len
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // The SEND cycle is the last of the GAP idle cycles, so the GAP state holds GAP-1 cycles.
  localparam logic [15:0] GAP_LAST  = (GAP > 1) ? 16'(GAP - 2) : 16'd0;
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [2:0]  idx;
  logic [2:0]  len_q;
  logic [31:0] pay_q;
  logic [7:0]  csum;
  logic [15:0] wdog;
  logic [15:0] gap_cnt;
  logic        last_grant;

  logic        req_eff0, req_eff1, any_req, g, len_ok, is_last;
  logic [2:0]  g_len;
  logic [31:0] g_pay;
  logic [7:0]  cur_byte;

  // A request still high during its own ack cycle is the one just served, not a new one.
  assign req_eff0 = req0 & ~ack0;
  assign req_eff1 = req1 & ~ack1;
  assign any_req  = req_eff0 | req_eff1;
  assign g        = (req_eff0 & req_eff1) ? ~last_grant : req_eff1;
  assign g_len    = g ? len1 : len0;
  assign g_pay    = g ? pay1 : pay0;
  assign len_ok   = (g_len != 3'd0) && (g_len <= 3'd4);
  assign is_last  = ({1'b0, idx} == ({1'b0, len_q} + 4'd2));
  assign busy     = (state != S_IDLE);

  always_comb begin
    // NOTE: default first so every path assigns cur_byte and no latch is inferred.
    cur_byte = csum;
    if (idx == 3'd0) begin
      cur_byte = HDR;
    end else if (idx == 3'd1) begin
      cur_byte = {grant_id, 4'b0000, len_q};
    end else if (!is_last) begin
      case (idx)
        3'd2:    cur_byte = pay_q[7:0];
        3'd3:    cur_byte = pay_q[15:8];
        3'd4:    cur_byte = pay_q[23:16];
        default: cur_byte = pay_q[31:24];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= 3'd0;
      len_q       <= 3'd0;
      pay_q       <= 32'd0;
      csum        <= 8'd0;
      wdog        <= 16'd0;
      gap_cnt     <= 16'd0;
      last_grant  <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      send_en     <= 1'b0;
      data        <= 8'd0;
      grant_id    <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here make every strobe a single-cycle pulse.
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      send_en     <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            ack0       <= ~g;
            ack1       <= g;
            grant_id   <= g;
            last_grant <= g;
            len_q      <= g_len;
            pay_q      <= g_pay;
            csum       <= 8'd0;
            idx        <= 3'd0;
            if (len_ok) state   <= S_SEND;
            else        err_len <= 1'b1;
          end
        end
        S_SEND: begin
          send_en <= 1'b1;
          data    <= cur_byte;
          wdog    <= 16'd0;
          if (idx != 3'd0 && !is_last) csum <= csum ^ cur_byte;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (is_last) begin
              state <= S_DONE;
            end else begin
              idx     <= idx + 3'd1;
              gap_cnt <= 16'd0;
              state   <= (GAP > 1) ? S_GAP : S_SEND;
            end
          end else if (wdog == WDOG_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state   <= S_SEND;
          else                     gap_cnt <= gap_cnt + 16'd1;
        end
        S_DONE: begin
          frame_done <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Self-checking bench for uart_frame_sched: directed cases plus randomized frames
// compared against a frame-level reference built from the framing rules.
module tb_uart_frame_sched;

  localparam int         TB_TIMEOUT = 200;
  localparam int         TB_GAP     = 2;
  localparam logic [7:0] TB_HDR     = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, ack0, ack1;
  logic [2:0]  len0, len1;
  logic [31:0] pay0, pay1;
  logic        send_en, tx_done, busy, grant_id, frame_done, err_timeout, err_len;
  logic [7:0]  data;

  uart_frame_sched #(.TIMEOUT(TB_TIMEOUT), .GAP(TB_GAP), .HDR(TB_HDR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .len0(len0), .pay0(pay0), .ack0(ack0),
    .req1(req1), .len1(len1), .pay1(pay1), .ack1(ack1),
    .send_en(send_en), .data(data), .tx_done(tx_done), .busy(busy),
    .grant_id(grant_id), .frame_done(frame_done),
    .err_timeout(err_timeout), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event log, sampled on the falling edge.
  logic [7:0] send_q[$];
  int         send_cyc_q[$];
  logic       ack_src_q[$];
  int         ack_cyc_q[$];
  int         fd_cyc_q[$];
  int         to_cyc_q[$];
  int         el_cnt   = 0;
  int         busy_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (send_en) begin send_q.push_back(data); send_cyc_q.push_back(cyc); end
      if (ack0 || ack1) begin ack_src_q.push_back(ack1); ack_cyc_q.push_back(cyc); end
      if (frame_done) fd_cyc_q.push_back(cyc);
      if (err_timeout) to_cyc_q.push_back(cyc);
      if (err_len) el_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // UART model: tx_done pulses tx_delay cycles after each send_en.
  int tx_delay  = 20;
  bit tx_enable = 1'b1;
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (send_en && tx_enable) begin
        repeat (tx_delay) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
      end
    end
  end

  // Reference frame: header, {src,0000,len}, payload LSB first, XOR of all but the header.
  logic [7:0] exp_q[$];
  function automatic void build_frame(input logic src, input logic [2:0] len, input logic [31:0] pay);
    logic [7:0] ck, b;
    exp_q.delete();
    exp_q.push_back(TB_HDR);
    ck = {src, 4'b0000, len};
    exp_q.push_back(ck);
    for (int i = 0; i < int'(len); i++) begin
      b = pay[8*i +: 8];
      exp_q.push_back(b);
      ck = ck ^ b;
    end
    exp_q.push_back(ck);
  endfunction

  task automatic do_req(input logic src, input logic [2:0] len, input logic [31:0] pay);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (src) begin req1 = 1'b1; len1 = len; pay1 = pay; end
    else     begin req0 = 1'b1; len0 = len; pay0 = pay; end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (src ? ack1 : ack0) begin got = 1'b1; break; end
    end
    check("ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic run_frame(input logic src, input logic [2:0] len, input logic [31:0] pay);
    int sb, ab, fb, eb, bb, budget;
    bit valid;
    sb = send_q.size(); ab = ack_src_q.size(); fb = fd_cyc_q.size();
    eb = el_cnt; bb = busy_cnt;
    valid = (len >= 3'd1 && len <= 3'd4);
    do_req(src, len, pay);
    if (ack_src_q.size() > ab) check("ack_src", 32'(ack_src_q[ab]), 32'(src));
    if (valid) begin
      build_frame(src, len, pay);
      budget = (int'(len) + 3) * (tx_delay + TB_GAP + 4) + 20;
      for (int i = 0; i < budget && fd_cyc_q.size() == fb; i++) @(posedge clk);
      #1;
      check("frame_done", 32'(fd_cyc_q.size() - fb), 32'd1);
      check("n_bytes", 32'(send_q.size() - sb), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && sb + k < send_q.size(); k++)
        check($sformatf("byte%0d", k), 32'(send_q[sb + k]), 32'(exp_q[k]));
      if (send_cyc_q.size() > sb && ack_cyc_q.size() > ab)
        check("ack_to_send", 32'(send_cyc_q[sb] - ack_cyc_q[ab]), 32'd1);
      for (int k = sb + 1; k < send_cyc_q.size(); k++)
        check("spacing", 32'(send_cyc_q[k] - send_cyc_q[k-1]), 32'(tx_delay + TB_GAP + 1));
      check("grant_id", 32'(grant_id), 32'(src));
      check("idle_after_frame", 32'(busy), 32'd0);
    end else begin
      repeat (5) @(posedge clk);
      #1;
      check("err_len", 32'(el_cnt - eb), 32'd1);
      check("no_send", 32'(send_q.size() - sb), 32'd0);
      check("busy_stays_0", 32'(busy_cnt - bb), 32'd0);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {20'd0, send_en, data, ack0, ack1, busy, grant_id, frame_done, err_timeout, err_len};
  endfunction

  initial begin
    int sb, fb, tb0, bb, ab, n_ack;
    logic src;
    logic [7:0] tie_exp[$];

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0; pay0 = '0; pay1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs_vec(), 32'd0);
    rst_n = 1'b1;

    // Directed frames from the two sources.
    tx_delay = 20;
    run_frame(1'b0, 3'd2, 32'h0000_3412);
    run_frame(1'b1, 3'd1, 32'h0000_00FF);

    // Rejected lengths.
    run_frame(1'b0, 3'd0, 32'h1122_3344);
    run_frame(1'b0, 3'd5, 32'h5566_7788);

    // Watchdog abort, then a normal frame.
    tx_enable = 1'b0;
    sb = send_q.size(); fb = fd_cyc_q.size(); tb0 = to_cyc_q.size();
    do_req(1'b0, 3'd2, 32'h0000_BEEF);
    for (int i = 0; i < TB_TIMEOUT + 50 && to_cyc_q.size() == tb0; i++) @(posedge clk);
    #1;
    check("err_timeout", 32'(to_cyc_q.size() - tb0), 32'd1);
    if (to_cyc_q.size() > tb0 && send_cyc_q.size() > sb)
      check("timeout_latency", 32'(to_cyc_q[tb0] - send_cyc_q[sb]), 32'(TB_TIMEOUT));
    check("bytes_before_abort", 32'(send_q.size() - sb), 32'd1);
    check("idle_after_timeout", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    check("no_frame_done", 32'(fd_cyc_q.size() - fb), 32'd0);
    tx_enable = 1'b1;
    run_frame(1'b0, 3'd3, 32'h00C0_FFEE);

    // Reset while waiting on the fourth byte.
    sb = send_q.size();
    do_req(1'b1, 3'd3, 32'h0012_3456);
    for (int i = 0; i < 200 && send_q.size() - sb < 4; i++) @(posedge clk);
    check("reached_byte3", 32'(send_q.size() - sb), 32'd4);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", outs_vec(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb = send_q.size(); bb = busy_cnt;
    repeat (100) @(posedge clk);
    #1;
    check("no_send_after_reset", 32'(send_q.size() - sb), 32'd0);
    check("idle_after_reset", 32'(busy_cnt - bb), 32'd0);

    // Both requesters held high out of reset: round-robin starting with 0.
    rst_n = 1'b0;
    req0 = 1'b1; len0 = 3'd1; pay0 = $urandom;
    req1 = 1'b1; len1 = 3'd1; pay1 = $urandom;
    sb = send_q.size(); ab = ack_src_q.size(); fb = fd_cyc_q.size();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_ack = 0;
    tie_exp.delete();
    for (int i = 0; i < 2000 && n_ack < 4; i++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) begin
        src = ack1;
        build_frame(src, 3'd1, src ? pay1 : pay0);
        foreach (exp_q[k]) tie_exp.push_back(exp_q[k]);
        n_ack++;
        @(posedge clk); #1;
        if (src) req1 = 1'b0; else req0 = 1'b0;
        if (n_ack == 4) begin req0 = 1'b0; req1 = 1'b0; end
        @(posedge clk); #1;
        if (n_ack < 4) begin
          if (src) begin pay1 = $urandom; req1 = 1'b1; end
          else     begin pay0 = $urandom; req0 = 1'b1; end
        end
      end
    end
    for (int i = 0; i < 500 && fd_cyc_q.size() - fb < 4; i++) @(posedge clk);
    #1;
    check("tie_frames", 32'(fd_cyc_q.size() - fb), 32'd4);
    check("tie_acks", 32'(ack_src_q.size() - ab), 32'd4);
    for (int k = 0; k < 4 && ab + k < ack_src_q.size(); k++)
      check($sformatf("tie_grant%0d", k), 32'(ack_src_q[ab + k]), 32'(k % 2));
    for (int k = 1; k < 4 && ab + k < ack_cyc_q.size() && fb + k - 1 < fd_cyc_q.size(); k++)
      check($sformatf("ack_after_done%0d", k), 32'(ack_cyc_q[ab + k] - fd_cyc_q[fb + k - 1]), 32'd1);
    check("tie_n_bytes", 32'(send_q.size() - sb), 32'(tie_exp.size()));
    for (int k = 0; k < tie_exp.size() && sb + k < send_q.size(); k++)
      check($sformatf("tie_byte%0d", k), 32'(send_q[sb + k]), 32'(tie_exp[k]));

    // Randomized single-source frames, including illegal lengths and varied UART latency.
    for (int n = 0; n < 24; n++) begin
      logic [2:0] rl;
      logic       rs;
      rs = 1'($urandom_range(0, 1));
      rl = 3'($urandom_range(0, 7));
      tx_delay = int'($urandom_range(1, 30));
      run_frame(rs, rl, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
